axis_case_conv: RTL and testbench
=================================

# axis_case_conv

Parametrised AXI4-Stream ASCII case converter, successor to the single-byte HLS stream converter in the PS-PL datapath. Accepts `BYTES` characters per beat and applies one of four modes: pass, upper, lower or toggle. The mode is latched per packet. Output goes through a 2-entry buffer, so `s_axis_tready` is registered and full throughput is kept under backpressure. Sits between the DMA MM2S stream and any downstream stream consumer.

## Interface
- `BYTES`, default 1: characters per beat, 1..16.
- `CNT_W`, default 32: width of the statistics counters.

Ports:
- `ap_clk` in 1: single clock; all logic rising-edge.
- `ap_rst` in 1: synchronous active-high reset.
- `mode` in 2: 0 = pass, 1 = upper, 2 = lower, 3 = toggle; sampled on the first beat of each packet.
- `s_axis_tdata` in 8*BYTES: lane i = bits [8i+7:8i].
- `s_axis_tkeep` in BYTES: lane valid mask.
- `s_axis_tlast` in 1: end of packet.
- `s_axis_tvalid` in 1: input valid.
- `s_axis_tready` out 1: registered ready.
- `m_axis_tdata` out 8*BYTES: converted data.
- `m_axis_tkeep` out BYTES: copied from input.
- `m_axis_tlast` out 1: copied from input.
- `m_axis_tvalid` out 1: output valid.
- `m_axis_tready` in 1: downstream ready.
- `busy` out 1: high while inside a packet (state `PKT`).
- `pkt_count` out CNT_W: present only with `AXIS_CASE_CONV_STATS_EN`.
- `conv_count` out CNT_W: present only with `AXIS_CASE_CONV_STATS_EN`.

## Operation
- Input accept: `s_axis_tvalid & s_axis_tready`.
- Output accept: `m_axis_tvalid & m_axis_tready`.
- Packet FSM:
  - `IDLE`: on an input accept with `tlast = 0`, latch `mode` into `mode_q` and go to `PKT`. On an input accept with `tlast = 1` (single-beat packet), use `mode` directly and stay in `IDLE`.
  - `PKT`: all beats use `mode_q`. Changes on `mode` are ignored until the next packet. An input accept with `tlast = 1` returns the FSM to `IDLE`.
- Effective mode: `IDLE ? mode : mode_q`.
- Per-lane conversion, combinational before the buffer write:
  - Only bytes in 0x41..0x5A or 0x61..0x7A are altered, by XOR with 0x20.
  - Upper clears bit 5 of 0x61..0x7A only. Lower sets bit 5 of 0x41..0x5A only. Toggle flips bit 5 of both ranges. Pass changes nothing.
  - All other byte values, and all lanes with `tkeep = 0`, pass unchanged.
- Output buffer: 2-entry FIFO holding {data, keep, last}; occupancy 0..2.
  - `m_axis_tvalid` = occupancy != 0, registered.
  - Output fields are driven from the head entry and held stable while `tvalid & !tready`.
  - `s_axis_tready` (registered) = next occupancy < 2.
- Simultaneous input and output accepts leave occupancy unchanged. At occupancy 1 this sustains one beat per cycle.
- Reset mid-packet:
  - Buffer contents are discarded; FSM goes to `IDLE`; `mode_q` = 0.
  - The partial packet is not completed or flagged.
  - Upstream must restart from a packet boundary.

## Timing
- Reset values: `s_axis_tready` = 0, `m_axis_tvalid` = 0, `m_axis_tdata`/`tkeep`/`tlast` = 0, `busy` = 0, counters = 0.
- `s_axis_tready` rises on the first cycle after `ap_rst` deasserts.
- Latency: a beat accepted at edge N is presented on `m_axis` from edge N, valid in cycle N+1.
- With `m_axis_tready` held high, throughput is one beat per cycle and occupancy stays at or below 1.
- With `m_axis_tready` low, two beats are absorbed. `s_axis_tready` falls on the edge that fills the second entry.
- `s_axis_tready` recovers one cycle after the first output accept.
- `busy` asserts the cycle after the first non-last input accept. It deasserts the cycle after the `tlast` input accept.

## Configuration
- `AXIS_CASE_CONV_STATS_EN` defined:
  - `pkt_count` increments on every input accept with `tlast = 1`.
  - `conv_count` increments by the number of lanes whose byte was altered in that beat (0..BYTES).
  - Both counters wrap modulo 2^CNT_W and are cleared by `ap_rst`.
- Not defined: both ports and all counter logic are absent; data behaviour is identical.

## Test plan
- BYTES = 1, mode = 1, packet "hello" (0x68 0x65 0x6C 0x6C 0x6F, tlast on the last beat), `m_axis_tready` = 1 → output 0x48 0x45 0x4C 0x4C 0x4F, tlast on the 5th beat, first output valid 1 cycle after the first input accept, no gaps.
- BYTES = 4, mode = 3, tdata 0x7A5B4120, tkeep 4'b1011 → tdata 0x5A5B6120 (0x5B non-alpha unchanged, 0x20 unchanged, 0x41 → 0x61), tkeep 4'b1011; `conv_count` += 2.
- Mode latching: packet "ab", "cd" with mode = 2 on the first beat, then mode switched to 1 before beat 2 → output "abcd" unchanged. The next packet, started with mode = 1, is uppercased.
- Backpressure: `m_axis_tready` = 0 for 6 cycles while 4 beats are offered → exactly 2 accepted, `s_axis_tready` = 0 until one cycle after `m_axis_tready` rises. All 4 beats delivered in order, data held stable while stalled.
- Reset mid-packet: assert `ap_rst` for 1 cycle after beat 2 of 5 with the buffer holding 1 entry → `m_axis_tvalid` = 0, `busy` = 0, counters = 0 next cycle; `s_axis_tready` = 1 the following cycle. A fresh packet converts with its own mode.
- Counter wrap (CNT_W = 4): 17 single-beat packets → `pkt_count` = 1.

Source files
------------

// File: rtl/axis_case_conv.sv
// axis_case_conv: AXI4-Stream ASCII case converter, BYTES characters per beat.
// Modes: 0 pass, 1 upper, 2 lower, 3 toggle; the mode is latched on the
// first beat of each packet. Output passes through a 2-entry buffer so that
// s_axis_tready is registered and full throughput is kept under backpressure.
// Optional feature macro: AXIS_CASE_CONV_STATS_EN adds pkt_count/conv_count.
//
// Handshake: a beat moves on a channel exactly on a rising edge where tvalid
// and tready are both high. A source holds tvalid and its payload stable until
// that edge. A sink may raise or drop tready freely. Neither direction's
// tvalid ever depends combinationally on the same channel's tready.
module axis_case_conv #(
    parameter int BYTES = 1,
    parameter int CNT_W = 32
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic [1:0]         mode,
    input  logic [8*BYTES-1:0] s_axis_tdata,
    input  logic [BYTES-1:0]   s_axis_tkeep,
    input  logic               s_axis_tlast,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    output logic [8*BYTES-1:0] m_axis_tdata,
    output logic [BYTES-1:0]   m_axis_tkeep,
    output logic               m_axis_tlast,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               busy
`ifdef AXIS_CASE_CONV_STATS_EN
    ,
    output logic [CNT_W-1:0]   pkt_count,
    output logic [CNT_W-1:0]   conv_count
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    state_t               state_q;
    logic [1:0]           mode_q;
    logic [1:0]           eff_mode;
    logic                 in_acc;
    logic                 out_acc;
    logic [8*BYTES-1:0]   conv_data;
    logic [1:0]           occ_q;
    logic [1:0]           occ_next;
    logic [8*BYTES-1:0]   tail_data;
    logic [BYTES-1:0]     tail_keep;
    logic                 tail_last;
`ifdef AXIS_CASE_CONV_STATS_EN
    logic [CNT_W-1:0]     alt_cnt;
`endif

    assign in_acc   = s_axis_tvalid & s_axis_tready;
    assign out_acc  = m_axis_tvalid & m_axis_tready;
    // Inside a packet the latched mode rules; between packets the live input.
    assign eff_mode = (state_q == PKT) ? mode_q : mode;

    // Packet tracker: latches the mode on the first beat of multi-beat packets;
    // busy is the registered image of the PKT state.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= IDLE;
            mode_q  <= 2'd0;
            busy    <= 1'b0;
        end else if (in_acc) begin
            case (state_q)
                IDLE: begin
                    if (!s_axis_tlast) begin
                        state_q <= PKT;
                        mode_q  <= mode;
                        busy    <= 1'b1;
                    end
                end
                PKT: begin
                    if (s_axis_tlast) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Per-lane conversion: only ASCII letters on kept lanes get bit 5 changed.
    always_comb begin
        logic [7:0] b;
        logic       is_up;
        logic       is_lo;
        logic       flip;
        conv_data = s_axis_tdata;
`ifdef AXIS_CASE_CONV_STATS_EN
        alt_cnt   = '0;
`endif
        for (int i = 0; i < BYTES; i++) begin
            b     = s_axis_tdata[8*i +: 8];
            is_up = (b >= 8'h41) && (b <= 8'h5A);
            is_lo = (b >= 8'h61) && (b <= 8'h7A);
            flip  = s_axis_tkeep[i] &
                    (((eff_mode == 2'd1) & is_lo) |
                     ((eff_mode == 2'd2) & is_up) |
                     ((eff_mode == 2'd3) & (is_up | is_lo)));
            conv_data[8*i +: 8] = b ^ {2'b00, flip, 5'b00000};
`ifdef AXIS_CASE_CONV_STATS_EN
            alt_cnt = alt_cnt + CNT_W'(flip);
`endif
        end
    end

    // Next buffer occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        occ_next = occ_q;
        case ({in_acc, out_acc})
            2'b10:   occ_next = occ_q + 2'd1;
            2'b01:   occ_next = occ_q - 2'd1;
            default: occ_next = occ_q;
        endcase
    end

    // Two-entry buffer: the head entry is the m_axis register set itself,
    // the tail entry refills the head when the head is consumed.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            occ_q         <= 2'd0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            tail_data     <= '0;
            tail_keep     <= '0;
            tail_last     <= 1'b0;
            s_axis_tready <= 1'b0;
        end else begin
            occ_q         <= occ_next;
            m_axis_tvalid <= (occ_next != 2'd0);
            s_axis_tready <= (occ_next < 2'd2);
            case (occ_q)
                2'd0: begin
                    if (in_acc) begin
                        m_axis_tdata <= conv_data;
                        m_axis_tkeep <= s_axis_tkeep;
                        m_axis_tlast <= s_axis_tlast;
                    end
                end
                2'd1: begin
                    if (in_acc && out_acc) begin
                        m_axis_tdata <= conv_data;
                        m_axis_tkeep <= s_axis_tkeep;
                        m_axis_tlast <= s_axis_tlast;
                    end else if (in_acc) begin
                        tail_data <= conv_data;
                        tail_keep <= s_axis_tkeep;
                        tail_last <= s_axis_tlast;
                    end
                end
                default: begin
                    if (out_acc) begin
                        m_axis_tdata <= tail_data;
                        m_axis_tkeep <= tail_keep;
                        m_axis_tlast <= tail_last;
                    end
                end
            endcase
        end
    end

`ifdef AXIS_CASE_CONV_STATS_EN
    // Statistics: packets seen and letters altered, both wrapping.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            pkt_count  <= '0;
            conv_count <= '0;
        end else if (in_acc) begin
            if (s_axis_tlast) begin
                pkt_count <= pkt_count + 1'b1;
            end
            conv_count <= conv_count + alt_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_axis_case_conv.sv
// tb_axis_case_conv: table vectors, hand-written corner sequences and random
// traffic for axis_case_conv (BYTES=4, CNT_W=4).
module tb_axis_case_conv;

  localparam int BYTES = 4;
  localparam int CNT_W = 4;

  logic              ap_clk = 1'b0;
  logic              ap_rst = 1'b1;
  logic [1:0]        mode = 2'd0;
  logic [31:0]       s_tdata = '0;
  logic [3:0]        s_tkeep = '0;
  logic              s_tlast = 1'b0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic [31:0]       m_tdata;
  logic [3:0]        m_tkeep;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready = 1'b1;
  logic              busy;
`ifdef AXIS_CASE_CONV_STATS_EN
  logic [CNT_W-1:0]  pkt_count;
  logic [CNT_W-1:0]  conv_count;
`endif

  axis_case_conv #(.BYTES(BYTES), .CNT_W(CNT_W)) dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .mode          (mode),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .busy          (busy)
`ifdef AXIS_CASE_CONV_STATS_EN
    ,
    .pkt_count     (pkt_count),
    .conv_count    (conv_count)
`endif
  );

  // ---------------- clock / cycle counter ----------------
  always #5 ap_clk = ~ap_clk;
  int cyc = 0;
  always @(posedge ap_clk) cyc++;

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad = 0;
  logic [36:0] exp_q[$];
  bit          in_pkt = 0;
  logic [1:0]  pkt_mode = 2'd0;
  logic [3:0]  exp_pkt = '0;
  logic [3:0]  exp_conv = '0;
  int          n_acc = 0;
  int          last_acc_cyc = 0;
  int          first_acc_cyc = 0;
  bit          rnd_rdy = 0;
  bit          drv_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: case conversion by the letter rules with plain arithmetic.
  function automatic logic [7:0] ref_char(input logic [7:0] c, input logic [1:0] m);
    bit up;
    bit lo;
    up = (c >= "A") && (c <= "Z");
    lo = (c >= "a") && (c <= "z");
    if ((m == 2'd1 || m == 2'd3) && lo) return c - 8'd32;
    if ((m == 2'd2 || m == 2'd3) && up) return c + 8'd32;
    return c;
  endfunction

  function automatic logic [31:0] ref_beat(input logic [31:0] d, input logic [3:0] k,
                                           input logic [1:0] m);
    logic [31:0] r;
    r = d;
    for (int i = 0; i < 4; i++)
      if (k[i]) r[8*i +: 8] = ref_char(d[8*i +: 8], m);
    return r;
  endfunction

  // ---------------- driver ----------------
  // Offers one beat from posedge+1; on acceptance the model records the
  // expected output (hand value if given, else the reference model).
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                           input logic [1:0] md, input bit has_exp, input logic [31:0] ex);
    int n;
    bit accepted;
    logic [31:0] e;
    n = 0;
    accepted = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    mode     = md;
    while (!accepted && n < 200) begin
      @(negedge ap_clk);
      if (s_tready && !ap_rst) begin
        accepted = 1;
        if (!in_pkt) pkt_mode = md;
        in_pkt = !l;
        e = has_exp ? ex : ref_beat(d, k, pkt_mode);
        for (int i = 0; i < 4; i++)
          if (e[8*i +: 8] != d[8*i +: 8]) exp_conv++;
        if (l) exp_pkt++;
        exp_q.push_back({e, k, l});
        n_acc++;
        last_acc_cyc = cyc;
      end
      @(posedge ap_clk);
      #1;
      n++;
    end
    s_tvalid = 1'b0;
    if (!accepted) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept expected accept of %0h", d);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic reset_dut();
    ap_rst = 1'b1;
    s_tvalid = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1;
    exp_q.delete();
    in_pkt = 0;
    exp_pkt = '0;
    exp_conv = '0;
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [36:0] held;
  bit          held_v = 0;
  always @(negedge ap_clk) begin
    if (ap_rst) begin
      held_v = 0;
    end else begin
      if (held_v) check("hold_stable", {m_tvalid, m_tdata, m_tkeep, m_tlast}, {1'b1, held});
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %0h expected nothing", {m_tdata, m_tkeep, m_tlast});
        end else begin
          check("out_beat", {m_tdata, m_tkeep, m_tlast}, exp_q.pop_front());
        end
      end
      held_v = m_tvalid && !m_tready;
      held   = {m_tdata, m_tkeep, m_tlast};
    end
  end

  // Random downstream ready while rnd_rdy is set.
  initial begin
    forever begin
      @(posedge ap_clk);
      #1;
      if (rnd_rdy) m_tready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  md;
    logic [31:0] data;
    logic [3:0]  keep;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic [7:0]  hello_in[5];
    logic [7:0]  hello_out[5];

    vecs[0] = '{2'd3, 32'h7A5B4120, 4'b1011, 32'h5A5B6120};
    vecs[1] = '{2'd1, 32'h61627A7B, 4'b1111, 32'h41425A7B};
    vecs[2] = '{2'd2, 32'h41405A5B, 4'b1111, 32'h61407A5B};
    vecs[3] = '{2'd0, 32'h41616263, 4'b1111, 32'h41616263};
    vecs[4] = '{2'd3, 32'h60417B5A, 4'b0000, 32'h60417B5A};
    vecs[5] = '{2'd1, 32'h00FF617A, 4'b0011, 32'h00FF415A};
    vecs[6] = '{2'd2, 32'h40415A5B, 4'b0110, 32'h40617A5B};
    vecs[7] = '{2'd3, 32'h6141617A, 4'b1111, 32'h4161415A};
    hello_in  = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    hello_out = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

    // Reset state
    repeat (2) @(posedge ap_clk);
    #1;
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_fields", {m_tdata, m_tkeep, m_tlast}, 0);
    check("rst_busy", busy, 0);
`ifdef AXIS_CASE_CONV_STATS_EN
    check("rst_counters", {pkt_count, conv_count}, 0);
`endif
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;
    check("ready_after_rst", s_tready, 1);

    // "hello", upper, no backpressure
    m_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_beat({24'h0, hello_in[i]}, 4'b0001, i == 4, 2'd1, 1, {24'h0, hello_out[i]});
      if (i == 0) begin
        first_acc_cyc = last_acc_cyc;
        check("hello_latency_valid", m_tvalid, 1);
        check("hello_busy_on", busy, 1);
      end
    end
    check("hello_no_gaps", last_acc_cyc - first_acc_cyc, 4);
    check("hello_busy_off", busy, 0);
    wait_drain();

    // Table of single-beat packets
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      send_beat(vecs[i].data, vecs[i].keep, 1'b1, vecs[i].md, 1, vecs[i].exp);
`ifdef AXIS_CASE_CONV_STATS_EN
      if (i == 0) check("conv_count_vec0", conv_count, 2);
`endif
    end
    wait_drain();
`ifdef AXIS_CASE_CONV_STATS_EN
    check("table_pkt_count", pkt_count, 8);
    check("table_conv_count", conv_count, 15);
`endif

    // Mode latching: "ab","cd" with lower latched, mode switched mid-packet
    send_beat(32'h00006261, 4'b0011, 1'b0, 2'd2, 1, 32'h00006261);
    send_beat(32'h00006463, 4'b0011, 1'b1, 2'd1, 1, 32'h00006463);
    send_beat(32'h00006261, 4'b0011, 1'b1, 2'd1, 1, 32'h00004241);
    wait_drain();

    // Backpressure: 4 beats offered against a stalled sink
    m_tready = 1'b0;
    n_acc = 0;
    drv_done = 0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send_beat(32'h61410000 + i, 4'b1111, i == 3, 2'd3, 0, '0);
        drv_done = 1;
      end
    join_none
    repeat (6) @(posedge ap_clk);
    #1;
    check("bp_accepted", n_acc, 2);
    check("bp_s_tready_low", s_tready, 0);
    check("bp_m_tvalid", m_tvalid, 1);
    m_tready = 1'b1;
    check("bp_ready_still_low", s_tready, 0);
    @(posedge ap_clk);
    #1;
    check("bp_ready_recovers", s_tready, 1);
    for (int n = 0; n < 100 && !drv_done; n++) begin
      @(posedge ap_clk);
      #1;
    end
    check("bp_driver_done", drv_done, 1);
    wait_drain();

    // Reset mid-packet with one entry buffered
    send_beat(32'h64636261, 4'b1111, 1'b0, 2'd1, 0, '0);
    send_beat(32'h68676665, 4'b1111, 1'b0, 2'd1, 0, '0);
    ap_rst = 1'b1;
    m_tready = 1'b0;
    exp_q.delete();
    in_pkt = 0;
    exp_pkt = '0;
    exp_conv = '0;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    check("midrst_m_tvalid", m_tvalid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_s_tready", s_tready, 0);
`ifdef AXIS_CASE_CONV_STATS_EN
    check("midrst_counters", {pkt_count, conv_count}, 0);
`endif
    @(posedge ap_clk);
    #1;
    check("midrst_ready_back", s_tready, 1);
    m_tready = 1'b1;
    send_beat(32'h00004241, 4'b0011, 1'b1, 2'd2, 1, 32'h00006261);
    wait_drain();

    // Random traffic with random backpressure against the reference model
    rnd_rdy = 1;
    for (int b = 0; b < 300; b++) begin
      for (int i = 0; i < 4; i++) d[8*i +: 8] = 8'($urandom_range(8'h38, 8'h7F));
      k = 4'($urandom_range(0, 15));
      l = (b == 299) ? 1'b1 : ($urandom_range(0, 3) == 0);
      send_beat(d, k, l, 2'($urandom_range(0, 3)), 0, '0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge ap_clk);
        #1;
      end
    end
    rnd_rdy = 0;
    m_tready = 1'b1;
    wait_drain();
`ifdef AXIS_CASE_CONV_STATS_EN
    check("rand_pkt_count", pkt_count, exp_pkt);
    check("rand_conv_count", conv_count, exp_conv);
`endif

`ifdef AXIS_CASE_CONV_STATS_EN
    // Counter wrap: 17 single-beat packets on 4-bit counters
    reset_dut();
    for (int i = 0; i < 17; i++)
      send_beat(32'h00000061, 4'b0001, 1'b1, 2'd1, 1, 32'h00000041);
    wait_drain();
    check("wrap_pkt_count", pkt_count, 1);
    check("wrap_conv_count", conv_count, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
